// File: rtl/pipelined_instruction_decoder_pkg.sv
// Shared types for the decode stage: opcode/funct typedefs, immediate kinds and the decoded bundle.
// Fields are sized for the widest XLEN so one bundle type serves both 32- and 64-bit builds.
package pipelined_instruction_decoder_pkg;

  localparam int unsigned XLEN_MAX = 64;

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } Opcode_t;

  typedef logic [2:0] Funct3_t;
  typedef logic [6:0] Funct7_t;

  typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} ImmType_t;

  // opcode is kept raw so an unknown major opcode is still visible downstream
  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [6:0]          opcode;
    Funct3_t             funct3;
    Funct7_t             funct7;
    logic [XLEN_MAX-1:0] imm;
    ImmType_t            imm_type;
    logic                illegal;
  } DecodedInstr_t;

  localparam int unsigned NUM_RV32I_OPCODES = 11;
  localparam Opcode_t RV32I_OPCODES [NUM_RV32I_OPCODES] = '{
    OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
    OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM
  };

  function automatic logic is_rv32i_opcode(input logic [6:0] op);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_RV32I_OPCODES; i++) begin
      if (op == RV32I_OPCODES[i]) hit = 1'b1;
      else                        hit = hit;
    end
    return hit;
  endfunction

  function automatic ImmType_t imm_type_of(input logic [6:0] op);
    ImmType_t t;
    case (op)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: t = IMM_I;
      OPC_STORE:                                              t = IMM_S;
      OPC_BRANCH:                                             t = IMM_B;
      OPC_LUI, OPC_AUIPC:                                     t = IMM_U;
      OPC_JAL:                                                t = IMM_J;
      default:                                                t = IMM_R;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/pipelined_instruction_decoder_decode_buffer.sv
// DEPTH-entry FIFO of decoded bundles with flush and an occupancy count (0..DEPTH inclusive).
module decode_buffer
  import pipelined_instruction_decoder_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  DecodedInstr_t            wdata,
  output DecodedInstr_t            rdata,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [AW:0]    occ_r;
  DecodedInstr_t  mem_r [DEPTH];

  // storage, pointers and count; reset also clears storage so the head reads as zero
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (pop) rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({push, pop})
        2'b10:   occ_r <= occ_r + 1'b1;
        2'b01:   occ_r <= occ_r - 1'b1;
        default: occ_r <= occ_r;
      endcase
    end
  end

  // at full with push+pop the write lands in the slot being read out this cycle
  assign rdata     = mem_r[rd_ptr_r];
  assign occupancy = occ_r;

endmodule

// File: rtl/pipelined_instruction_decoder.sv
// Registered decode stage between fetch and execute. Optional illegal-opcode detection is
// enabled by defining JZJCOREF_ILLEGAL_INSN_DETECT_EN; otherwise illegal is tied to 0.
module pipelined_instruction_decoder
  import pipelined_instruction_decoder_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [31:0]             in_instr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output DecodedInstr_t           out_bundle,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [XLEN_MAX-1:0] XLEN_MASK =
    (XLEN == 64) ? {XLEN_MAX{1'b1}} : {32'h0000_0000, 32'hFFFF_FFFF};

  DecodedInstr_t        dec_s;
  logic [XLEN_MAX-1:0]  imm_sel_s;
  logic                 push_s;
  logic                 pop_s;

  // immediate selection, sign-extended to 64 then trimmed to XLEN
  always_comb begin
    imm_sel_s = '0;
    case (imm_type_of(in_instr[6:0]))
      IMM_I:   imm_sel_s = {{52{in_instr[31]}}, in_instr[31:20]};
      IMM_S:   imm_sel_s = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      IMM_B:   imm_sel_s = {{51{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                            in_instr[11:8], 1'b0};
      IMM_U:   imm_sel_s = {{32{in_instr[31]}}, in_instr[31:12], 12'h000};
      IMM_J:   imm_sel_s = {{43{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                            in_instr[30:21], 1'b0};
      default: imm_sel_s = '0;
    endcase
    imm_sel_s = imm_sel_s & XLEN_MASK;
  end

  // field decode feeding the buffer write port
  always_comb begin
    dec_s          = '0;
    dec_s.pc       = XLEN_MAX'(in_pc);
    dec_s.rs1      = in_instr[19:15];
    dec_s.rs2      = in_instr[24:20];
    dec_s.rd       = in_instr[11:7];
    dec_s.opcode   = in_instr[6:0];
    dec_s.funct3   = in_instr[14:12];
    dec_s.funct7   = in_instr[31:25];
    dec_s.imm_type = imm_type_of(in_instr[6:0]);
`ifdef JZJCOREF_ILLEGAL_INSN_DETECT_EN
    dec_s.illegal  = !is_rv32i_opcode(in_instr[6:0]) || (in_instr[1:0] != 2'b11);
    if (dec_s.illegal) begin
      dec_s.imm = '0;
      dec_s.rd  = 5'd0;
    end else begin
      dec_s.imm = imm_sel_s;
    end
`else
    dec_s.illegal  = 1'b0;
    dec_s.imm      = imm_sel_s;
`endif
  end

  // flush keeps the stage open so fetch is never blocked by a redirect
  assign in_ready  = flush || (occupancy < DEPTH_C) || out_ready;
  assign out_valid = (occupancy != '0);
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;

  decode_buffer #(.DEPTH(DEPTH)) u_buffer (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .push      (push_s),
    .pop       (pop_s),
    .wdata     (dec_s),
    .rdata     (out_bundle),
    .occupancy (occupancy)
  );

endmodule
